// File: rtl/frame_reduce_pkg.sv
// frame_reduce_pkg
//   Shared definitions for the frame reduction controller: op codes, the
//   reduction class/invert encoding, FSM states and the op_sel decoder.
package frame_reduce_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    CLS_AND = 2'd0,
    CLS_OR  = 2'd1,
    CLS_XOR = 2'd2
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    logic      inv;
    logic      illegal;
  } op_dec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Split an op code into reduction class + final inversion.
  // Codes 6/7 are illegal and fall back to plain XOR.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.cls     = CLS_XOR;
    d.inv     = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OP_AND:  d.cls = CLS_AND;
      OP_OR:   d.cls = CLS_OR;
      OP_XOR:  d.cls = CLS_XOR;
      OP_NAND: begin d.cls = CLS_AND; d.inv = 1'b1; end
      OP_NOR:  begin d.cls = CLS_OR;  d.inv = 1'b1; end
      OP_XNOR: begin d.cls = CLS_XOR; d.inv = 1'b1; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/frame_reduce_ctrl_word_reduce.sv
// word_reduce_unit
//   Combinational reduction of one WIDTH-bit word.
//   word    : input word
//   red_and : &word
//   red_or  : |word
//   red_xor : ^word
module word_reduce_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
);

  assign red_and = &word;
  assign red_or  = |word;
  assign red_xor = ^word;

endmodule

// File: rtl/frame_reduce_ctrl.sv
// frame_reduce_ctrl
//   Folds every bit of every word in a frame into one AND/OR/XOR result,
//   optionally inverted, and hands it off with the frame's beat count.
//   clk, rst          : clock, async active-high reset
//   in_valid/in_ready : input beat handshake (in_ready depends on state only)
//   in_data, in_last  : beat payload and end-of-frame marker
//   op_sel            : op code, sampled on the first beat of a frame only
//   out_valid/out_ready: result handshake
//   out_result        : reduction result (registered)
//   out_count         : beats in the completed frame (registered)
//   err               : sticky, set when an illegal op code starts a frame
import frame_reduce_pkg::*;

module frame_reduce_ctrl #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             err
);

  state_e           state;
  op_class_e        cls_q;
  logic             inv_q;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  logic             w_and, w_or, w_xor;
  op_dec_t          dec;
  logic             seed;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             close_accum;

  word_reduce_unit #(.WIDTH(WIDTH)) u_red (
    .word    (in_data),
    .red_and (w_and),
    .red_or  (w_or),
    .red_xor (w_xor)
  );

  assign dec = decode_op(op_sel);

  always_comb begin
    // first beat: accumulator starts as the word's own reduction
    case (dec.cls)
      CLS_AND: seed = w_and;
      CLS_OR:  seed = w_or;
      default: seed = w_xor;
    endcase
    // later beats fold in using the class latched on the first beat
    case (cls_q)
      CLS_AND: acc_nxt = acc & w_and;
      CLS_OR:  acc_nxt = acc | w_or;
      default: acc_nxt = acc ^ w_xor;
    endcase
    cnt_nxt     = cnt + 1'b1;
    // in_last and hitting FRAME_LEN on the same beat close the frame once
    close_accum = in_last || (cnt_nxt == CNT_W'(FRAME_LEN));
  end

  assign in_ready = (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cls_q      <= CLS_AND;
      inv_q      <= 1'b0;
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_count  <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cls_q <= dec.cls;
            inv_q <= dec.inv;
            acc   <= seed;
            cnt   <= CNT_W'(1);
            if (dec.illegal) err <= 1'b1;
            if (in_last || FRAME_LEN == 1) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= seed ^ dec.inv;
              out_count  <= CNT_W'(1);
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (close_accum) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= acc_nxt ^ inv_q;
              out_count  <= cnt_nxt;
            end
          end
        end
        DONE: begin
          // result registers keep their value after the handshake
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reduce_ctrl.sv
module tb_frame_reduce_ctrl;
  localparam int W  = 4;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  in_data = 0;
  logic          in_last = 0;
  logic [2:0]    op_sel = 0;
  logic          out_valid;
  logic          out_ready = 0;
  logic          out_result;
  logic [CW-1:0] out_count;
  logic          err;

  int total = 0;
  int bad   = 0;

  frame_reduce_ctrl #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame summarised as: beats so far, all words all-ones, any nonzero word,
  // total ones count. Result follows from op code directly.
  int         m_cnt = 0;
  logic       m_all = 1, m_any = 0;
  int         m_ones = 0;
  logic [2:0] m_op = 0;
  logic       m_have = 0, m_err = 0, m_res = 0;
  int         m_n = 0;

  function automatic logic mres(input logic [2:0] op, input logic all, input logic any,
                                input int ones);
    logic r;
    case (op)
      3'd0, 3'd3: r = all;
      3'd1, 3'd4: r = any;
      default:    r = ones[0];
    endcase
    return r ^ (op == 3'd3 || op == 3'd4 || op == 3'd5);
  endfunction

  wire [2:0]  cur_op = (m_cnt == 0) ? op_sel : m_op;
  wire        n_all  = (m_cnt == 0 || m_all) && (in_data == 4'hF);
  wire        n_any  = (m_cnt != 0 && m_any) || (in_data != 0);
  wire [31:0] n_ones = (m_cnt == 0 ? 0 : m_ones) + $countones(in_data);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_all <= 1; m_any <= 0; m_ones <= 0; m_op <= 0;
      m_have <= 0; m_err <= 0; m_res <= 0; m_n <= 0;
    end else if (m_have) begin
      if (out_ready) m_have <= 0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_op <= op_sel;
        if (op_sel > 3'd5) m_err <= 1;
      end
      if (in_last || m_cnt + 1 == FL) begin
        m_have <= 1;
        m_n    <= m_cnt + 1;
        m_res  <= mres(cur_op, n_all, n_any, n_ones);
        m_cnt  <= 0;
      end else begin
        m_cnt  <= m_cnt + 1;
        m_all  <= n_all;
        m_any  <= n_any;
        m_ones <= n_ones;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_have);
    chk("out_valid", out_valid, m_have);
    chk("err", err, m_err);
    if (m_have) begin
      chk("out_result", out_result, m_res);
      chk("out_count", out_count, m_n);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input logic [W-1:0] w, input logic last, input logic [2:0] op);
    int k = 0;
    @(negedge clk); #1;
    in_valid = 1; in_data = w; in_last = last; op_sel = op;
    while (!in_ready && k < 50) begin @(negedge clk); #1; k++; end
    if (k >= 50) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic take(input string nm, input logic r, input int n);
    int k = 0;
    @(negedge clk); #1;
    while (!out_valid && k < 50) begin @(negedge clk); #1; k++; end
    if (k >= 50) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_res"}, out_result, r);
    chk({nm, "_cnt"}, out_count, n);
    chk({nm, "_model"}, m_res, r);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_count", out_count, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); #1; rst = 0;

    // 1: AND
    send(4'hF, 0, 0); send(4'hF, 0, 0); send(4'hF, 0, 0); send(4'hF, 0, 0);
    take("and_ffff", 1, 4);
    send(4'hF, 0, 0); send(4'hF, 0, 0); send(4'h7, 0, 0); send(4'hF, 0, 0);
    take("and_ff7f", 0, 4);
    // 2: XOR
    send(4'h1, 0, 2); send(4'h3, 1, 2);
    take("xor_13", 1, 2);
    send(4'h6, 1, 2);
    take("xor_6", 0, 1);
    // 3: NOR, op_sel changing mid-frame ignored
    send(4'h0, 0, 4); send(4'h0, 0, 4); send(4'h0, 0, 4); send(4'h0, 0, 4);
    take("nor_0000", 1, 4);
    send(4'h0, 0, 4); send(4'h8, 0, 0); send(4'h0, 0, 0); send(4'h0, 0, 0);
    take("nor_0800", 0, 4);
    // 4: backpressure
    send(4'hF, 0, 0); send(4'hF, 0, 0); send(4'hF, 0, 0); send(4'hF, 0, 0);
    @(negedge clk); #1;
    in_valid = 1; in_data = 4'h0; op_sel = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 1);
      chk("bp_count", out_count, 4);
    end
    #1 out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    // 5: illegal op, sticky err
    send(4'h1, 0, 6); send(4'h0, 0, 6); send(4'h0, 0, 6); send(4'h0, 0, 6);
    chk("ill_err", err, 1);
    take("ill_xor", 1, 4);
    send(4'hF, 1, 0);
    take("ill_next", 1, 1);
    chk("ill_err_sticky", err, 1);
    @(negedge clk); #1; rst = 1;
    @(negedge clk); #1; rst = 0;
    chk("ill_err_cleared", err, 0);
    // 6: async reset mid-frame
    send(4'h3, 0, 1); send(4'h1, 0, 1);
    @(posedge clk); #3; rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_count", out_count, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk); #1; rst = 0;
    send(4'h0, 0, 1); send(4'h0, 0, 1); send(4'h0, 0, 1); send(4'h2, 0, 1);
    take("arst_or", 1, 4);

    // random phase, checked by the compare process
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      op_sel    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 1) == 1);
      if (i == 300) rst = 1;
      if (i == 302) rst = 0;
    end
    @(negedge clk); #1;
    in_valid = 0; out_ready = 1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
